vp_validation_queue: RTL
========================

Name: vp_validation_queue

Overview:
- Sits directly downstream of the last-value predictor and feeds its feedback (fb_*) interface.
- Buffers in-flight predictions (pc, predicted value, confidence) in program order until execution results retire.
- Compares each prediction against the retired result and emits one registered fb_* record per matched instruction: pc, actual value, mispredict flag, confidence bit.
- Multi-lane circular queue, P_NUM_PRED enqueues and dequeues per cycle.

Parameters:
P_NUM_PRED, 2, lanes per cycle on every interface; legal values 1 or 2
P_QUEUE_DEPTH, 16, entries; power of 2, >= 2*P_NUM_PRED
P_DROP_CNT_WIDTH, 16, width of saturating drop counter

Ports:
clk_i  in  1  main clock
rst_ni  in  1  asynchronous active-low reset
pred_pc_i  in  [P_NUM_PRED][32]  predicted instruction pc, from predictor
pred_result_i  in  [P_NUM_PRED][32]  predicted value
pred_conf_i  in  [P_NUM_PRED]  confidence saturated bit
pred_valid_i  in  [P_NUM_PRED]  per-lane qualifier
exe_pc_i  in  [P_NUM_PRED][32]  retired instruction pc, program order, lane 0 oldest
exe_actual_i  in  [P_NUM_PRED][32]  true execution result
exe_valid_i  in  [P_NUM_PRED]  per-lane qualifier
flush_i  in  1  squash all in-flight entries
fb_pc_o  out  [P_NUM_PRED][32]  feedback pc
fb_actual_o  out  [P_NUM_PRED][32]  feedback actual value
fb_mispredict_o  out  [P_NUM_PRED]  predicted != actual
fb_conf_o  out  [P_NUM_PRED]  stored confidence bit
fb_valid_o  out  [P_NUM_PRED]  per-lane qualifier
count_o  out  clog2(P_QUEUE_DEPTH)+1  occupied entries
full_o  out  1  count_o == P_QUEUE_DEPTH
drop_cnt_o  out  P_DROP_CNT_WIDTH  saturating count of dropped prediction groups

Behaviour:
- Reset (rst_ni low, async): head = tail = 0, count_o = 0, drop_cnt_o = 0, and all fb_* outputs = 0. full_o = 0. Storage contents are don't-care.
- Enqueue:
  - Valid pred lanes are compacted in lane order (lane 0 first) and written at tail, tail+1.
  - Pointers wrap modulo P_QUEUE_DEPTH.
  - Admission is all-or-nothing per cycle. The group is written only if (P_QUEUE_DEPTH - count) >= popcount(pred_valid_i), using count from the start of the cycle; same-cycle pops do not free space.
  - A rejected group increments drop_cnt_o by 1, saturating at all-ones. No entries are written.
- Dequeue and match:
  - Exe lane 0 compares exe_pc_i[0] against the head entry, when count >= 1.
  - On equality, the head is popped and lane-0 feedback is produced.
  - On inequality, or when the queue is empty, nothing is popped and there is no feedback. The instruction is treated as unpredicted (e.g. its group was dropped).
  - Exe lane 1 compares against head+1 if lane 0 popped, otherwise against head. It follows the same rule.
  - Entries enqueued this cycle are not visible to this cycle's exe lanes.
- Feedback:
  - Registered, exactly 1 cycle after the matching exe beat.
  - fb_pc_o = entry pc, fb_actual_o = exe_actual_i, fb_mispredict_o = (entry result != exe_actual_i), fb_conf_o = entry conf.
  - fb_valid_o is high only for matched lanes. Unmatched lanes drive fb_valid = 0 with the data fields held at their previous values.
  - Lane 0 is older than lane 1 on the feedback interface.
- Count: count_next = count + pushed - popped. The range is 0..P_QUEUE_DEPTH, and full_o is combinational from count.
- Flush (flush_i high):
  - That cycle's exe lanes still match against pre-flush contents and produce feedback normally.
  - At the clock edge head = tail and count = 0.
  - That cycle's pred group is discarded without incrementing drop_cnt_o.
  - Flush has priority over enqueue.
- Reset mid-operation: async clear of all state, fb_valid_o drops immediately, and in-flight entries are lost.
- P_NUM_PRED == 1: lane 1 logic is absent and behaviour reduces to a single-lane FIFO with match.

Test Plan:
- Single in-order match: pred pc=0x100, result=0x5, conf=1. Next cycle exe pc=0x100, actual=0x5 -> one cycle later fb_valid=01, fb_pc=0x100, fb_mispredict=0, fb_conf=1; count returns 0.
- Dual-lane mispredict: pred lanes {0x200:0x7, 0x204:0x9}. Then exe both lanes {0x200:0x7, 0x204:0xA} -> fb_valid=11, fb_mispredict=10 (lane1 wrong), fb_actual[1]=0xA.
- Overflow drop, depth 4: enqueue 2+2 (count=4, full_o=1), then a 1-lane group -> drop_cnt_o=1, count stays 4; draining 2 per cycle empties in 2 cycles in original order.
- Unmatched exe: queue holds 0x300. Exe pc=0x2FC -> no feedback, count unchanged. Next exe pc=0x300 -> feedback for 0x300.
- Flush with simultaneous retire: queue {0x400, 0x404, 0x408}. Same cycle flush_i=1, exe lane0 pc=0x400, pred valid pc=0x500 -> fb for 0x400 next cycle, count=0, drop_cnt_o unchanged; subsequent exe 0x404 gives no feedback.
- Wrap-around plus async reset: 20 push/pop pairs cross the pointer wrap at depth 16 with correct order; assert rst_ni low mid-stream -> fb_valid_o and count_o read 0 before the next clock edge.

Source files
------------

// File: rtl/vp_validation_queue.sv
// Validation queue between the last-value predictor and its feedback port.
// Holds predictions in program order and scores each one against its retired result.
module vp_validation_queue #(
    parameter int P_NUM_PRED       = 2,
    parameter int P_QUEUE_DEPTH    = 16,
    parameter int P_DROP_CNT_WIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [P_NUM_PRED-1:0][31:0]         pred_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]         pred_result_i,
    input  logic [P_NUM_PRED-1:0]               pred_conf_i,
    input  logic [P_NUM_PRED-1:0]               pred_valid_i,
    input  logic [P_NUM_PRED-1:0][31:0]         exe_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]         exe_actual_i,
    input  logic [P_NUM_PRED-1:0]               exe_valid_i,
    input  logic                                flush_i,
    output logic [P_NUM_PRED-1:0][31:0]         fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]         fb_actual_o,
    output logic [P_NUM_PRED-1:0]               fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]               fb_conf_o,
    output logic [P_NUM_PRED-1:0]               fb_valid_o,
    output logic [$clog2(P_QUEUE_DEPTH):0]      count_o,
    output logic                                full_o,
    output logic [P_DROP_CNT_WIDTH-1:0]         drop_cnt_o
);

    localparam int AW = $clog2(P_QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(P_QUEUE_DEPTH);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    logic [31:0] mem_pc   [P_QUEUE_DEPTH];
    logic [31:0] mem_res  [P_QUEUE_DEPTH];
    logic        mem_conf [P_QUEUE_DEPTH];

    logic [CW-1:0]         n_push;
    logic [CW-1:0]         n_pop;
    logic [CW-1:0]         space;
    logic [AW-1:0]         wr_off [P_NUM_PRED];
    logic [AW-1:0]         rd_idx [P_NUM_PRED];
    logic [P_NUM_PRED-1:0] hit;
    logic                  accept;
    logic                  drop;

    // Valid pred lanes are compacted: each lane writes at tail + (valid lanes below it).
    always_comb begin
        n_push = '0;
        for (int i = 0; i < P_NUM_PRED; i++) begin
            wr_off[i] = n_push[AW-1:0];
            n_push    = n_push + CW'(pred_valid_i[i]);
        end
    end

    // Space is judged on the count at the start of the cycle, so same-cycle pops never help.
    assign space  = DEPTH_C - count_o;
    assign accept = !flush_i && (n_push != '0) && (space >= n_push);
    assign drop   = !flush_i && (space < n_push);

    // Each exe lane looks at the entry just past whatever the older lanes popped.
    always_comb begin
        n_pop = '0;
        hit   = '0;
        for (int i = 0; i < P_NUM_PRED; i++) begin
            rd_idx[i] = head + n_pop[AW-1:0];
            hit[i]    = exe_valid_i[i] && (count_o > n_pop) &&
                        (exe_pc_i[i] == mem_pc[rd_idx[i]]);
            n_pop     = n_pop + CW'(hit[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < P_NUM_PRED; i++) begin
                if (pred_valid_i[i]) begin
                    mem_pc[tail + wr_off[i]]   <= pred_pc_i[i];
                    mem_res[tail + wr_off[i]]  <= pred_result_i[i];
                    mem_conf[tail + wr_off[i]] <= pred_conf_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head    <= '0;
            tail    <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            // Matches this cycle still read the old contents; the queue empties at the edge.
            head    <= tail;
            count_o <= '0;
        end else begin
            head <= head + n_pop[AW-1:0];
            if (accept) begin
                tail    <= tail + n_push[AW-1:0];
                count_o <= count_o - n_pop + n_push;
            end else begin
                count_o <= count_o - n_pop;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (drop && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    // Unmatched lanes keep their last data; only the qualifier drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fb_pc_o         <= '0;
            fb_actual_o     <= '0;
            fb_mispredict_o <= '0;
            fb_conf_o       <= '0;
            fb_valid_o      <= '0;
        end else begin
            fb_valid_o <= hit;
            for (int i = 0; i < P_NUM_PRED; i++) begin
                if (hit[i]) begin
                    fb_pc_o[i]         <= mem_pc[rd_idx[i]];
                    fb_actual_o[i]     <= exe_actual_i[i];
                    fb_mispredict_o[i] <= (mem_res[rd_idx[i]] != exe_actual_i[i]);
                    fb_conf_o[i]       <= mem_conf[rd_idx[i]];
                end
            end
        end
    end

    assign full_o = (count_o == DEPTH_C);

endmodule
